// File: rtl/alloc_pkg.sv
// Shared sizing for the slot allocator: default index width and counter width.
package alloc_pkg;
  localparam int IDX_W_DEF = 3;

  // The counter needs one extra bit so that it can hold N itself.
  function automatic int cnt_w(input int idx_w);
    return idx_w + 1;
  endfunction
endpackage

// File: rtl/onehot_dec.sv
// Enabled binary to one-hot decoder; purely combinational, output all zero when disabled.
module onehot_dec #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      i_idx,
  input  logic                 i_en,
  output logic [2**IN_W-1:0]   o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/onehot_slot_alloc.sv
// Lowest-index-first slot allocator with release, flush and occupancy count.
// Grant is combinational from registered occupancy; all status outputs are registered.
module onehot_slot_alloc
  import alloc_pkg::*;
#(
  parameter  int IDX_W = IDX_W_DEF,
  localparam int N     = 2**IDX_W,
  localparam int CW    = cnt_w(IDX_W)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  output logic [N-1:0]     alloc_onehot,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             flush,
  output logic [N-1:0]     busy_vec,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             free_err
);
  logic [N-1:0]     r_busy;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_free_err;

  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_rel_ok;
  logic             w_rel_bad;
  logic [N-1:0]     w_gnt_oh;
  logic [N-1:0]     w_rel_oh;
  logic [N-1:0]     w_busy_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Descending scan so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_pick = IDX_W'(i);
        w_any  = 1'b1;
      end
    end
  end

  assign alloc_gnt = resetn & alloc_req & ~flush & w_any;
  assign alloc_idx = alloc_gnt ? w_pick : '0;

  assign w_rel_ok  = resetn & free_valid & ~flush &  r_busy[free_idx];
  assign w_rel_bad = resetn & free_valid & ~flush & ~r_busy[free_idx];

  onehot_dec #(.IN_W(IDX_W)) u_gnt_dec (
    .i_idx    (w_pick),
    .i_en     (alloc_gnt),
    .o_onehot (w_gnt_oh)
  );

  onehot_dec #(.IN_W(IDX_W)) u_rel_dec (
    .i_idx    (free_idx),
    .i_en     (w_rel_ok),
    .o_onehot (w_rel_oh)
  );

  assign alloc_onehot = w_gnt_oh;

  // A granted slot is always free and a released one always busy, so they never collide.
  assign w_busy_nxt = (r_busy | w_gnt_oh) & ~w_rel_oh;
  assign w_cnt_nxt  = r_count + CW'(alloc_gnt) - CW'(w_rel_ok);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_busy     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_free_err <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == CW'(N));
      r_empty    <= (w_cnt_nxt == '0);
      r_free_err <= w_rel_bad;
    end
  end

  assign busy_vec = r_busy;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;
  assign free_err = r_free_err;
endmodule

// File: tb/tb_onehot_slot_alloc.sv
// Scoreboard bench: directed IDX_W=3 vectors plus IDX_W=6 random traffic against a model.
module tb_onehot_slot_alloc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn3 = 1'b0, req3 = 1'b0, fv3 = 1'b0, fl3 = 1'b0;
  logic [2:0] fidx3 = '0;
  logic       gnt3, full3, empty3, err3;
  logic [2:0] idx3;
  logic [7:0] oh3, busy3;
  logic [3:0] cnt3;

  logic        rstn6 = 1'b0, req6 = 1'b0, fv6 = 1'b0, fl6 = 1'b0;
  logic [5:0]  fidx6 = '0;
  logic        gnt6, full6, empty6, err6;
  logic [5:0]  idx6;
  logic [63:0] oh6, busy6;
  logic [6:0]  cnt6;

  onehot_slot_alloc #(.IDX_W(3)) u_dut3 (
    .clk(clk), .resetn(rstn3), .alloc_req(req3), .alloc_gnt(gnt3), .alloc_idx(idx3),
    .alloc_onehot(oh3), .free_valid(fv3), .free_idx(fidx3), .flush(fl3),
    .busy_vec(busy3), .count(cnt3), .full(full3), .empty(empty3), .free_err(err3)
  );

  onehot_slot_alloc #(.IDX_W(6)) u_dut6 (
    .clk(clk), .resetn(rstn6), .alloc_req(req6), .alloc_gnt(gnt6), .alloc_idx(idx6),
    .alloc_onehot(oh6), .free_valid(fv6), .free_idx(fidx6), .flush(fl6),
    .busy_vec(busy6), .count(cnt6), .full(full6), .empty(empty6), .free_err(err6)
  );

  typedef struct {
    bit          sel6;
    logic        gnt;
    logic [5:0]  idx;
    logic [63:0] busy;
    logic [6:0]  cnt;
    logic        err;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h @%0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  exp_t        m;
  logic [63:0] m_oh;
  int          m_n;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m    = q.pop_front();
      m_oh = m.gnt ? (64'd1 << m.idx) : 64'd0;
      m_n  = m.sel6 ? 64 : 8;
      if (!m.sel6) begin
        chk("gnt", m.tag, 64'(gnt3), 64'(m.gnt));
        chk("idx", m.tag, 64'(idx3), 64'(m.idx));
        chk("onehot", m.tag, 64'(oh3), m_oh);
        chk("busy", m.tag, 64'(busy3), m.busy);
        chk("count", m.tag, 64'(cnt3), 64'(m.cnt));
        chk("full", m.tag, 64'(full3), 64'(int'(m.cnt) == m_n));
        chk("empty", m.tag, 64'(empty3), 64'(m.cnt == 0));
        chk("free_err", m.tag, 64'(err3), 64'(m.err));
      end else begin
        chk("gnt", m.tag, 64'(gnt6), 64'(m.gnt));
        chk("idx", m.tag, 64'(idx6), 64'(m.idx));
        chk("onehot", m.tag, oh6, m_oh);
        chk("busy", m.tag, busy6, m.busy);
        chk("count", m.tag, 64'(cnt6), 64'(m.cnt));
        chk("full", m.tag, 64'(full6), 64'(int'(m.cnt) == m_n));
        chk("empty", m.tag, 64'(empty6), 64'(m.cnt == 0));
        chk("free_err", m.tag, 64'(err6), 64'(m.err));
      end
    end
  end

  task automatic s(input logic rn, input logic rq, input logic v, input logic [2:0] fi, input logic f,
                   input logic eg, input logic [2:0] ei, input logic [7:0] eb, input logic [3:0] ec,
                   input logic ee, input string tag);
    exp_t e;
    @(posedge clk); #1;
    rstn3 = rn; req3 = rq; fv3 = v; fidx3 = fi; fl3 = f;
    e.sel6 = 1'b0; e.gnt = eg; e.idx = 6'(ei); e.busy = 64'(eb); e.cnt = 7'(ec); e.err = ee; e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    logic [63:0] mb;
    logic        me, eg, any;
    logic [5:0]  li;
    exp_t        e;

    // Reset holds even with flush/alloc/free asserted.
    s(0,1,1,3'd0,1, 0,3'd0,8'h00,4'd0,0,"reset");
    for (int k = 0; k < 8; k++) s(1,1,0,3'd0,0, 1,3'(k),8'((1 << k) - 1),4'(k),0,"fill");
    s(1,1,0,3'd0,0, 0,3'd0,8'hFF,4'd8,0,"full_nogrant");
    s(1,1,1,3'd5,0, 0,3'd0,8'hFF,4'd8,0,"free5_same_cycle");
    s(1,1,0,3'd0,0, 1,3'd5,8'hDF,4'd7,0,"regrant5");
    s(1,0,0,3'd0,0, 0,3'd0,8'hFF,4'd8,0,"refull");
    s(1,1,1,3'd3,1, 0,3'd0,8'hFF,4'd8,0,"flush_full");
    for (int k = 0; k < 4; k++) s(1,1,0,3'd0,0, 1,3'(k),8'((1 << k) - 1),4'(k),0,"fill4");
    s(1,1,1,3'd2,0, 1,3'd4,8'h0F,4'd4,0,"alloc_free2");
    s(1,0,0,3'd0,0, 0,3'd0,8'h1B,4'd4,0,"busy_1b");
    s(1,0,0,3'd0,1, 0,3'd0,8'h1B,4'd4,0,"flush2");
    s(1,1,0,3'd0,0, 1,3'd0,8'h00,4'd0,0,"alloc0");
    s(1,0,1,3'd6,0, 0,3'd0,8'h01,4'd1,0,"free_bad6");
    s(1,0,0,3'd0,0, 0,3'd0,8'h01,4'd1,1,"err_pulse");
    s(1,0,0,3'd0,0, 0,3'd0,8'h01,4'd1,0,"err_clear");
    s(1,1,1,3'd0,0, 1,3'd1,8'h01,4'd1,0,"free0_alloc");
    s(1,1,0,3'd0,0, 1,3'd0,8'h02,4'd1,0,"slot0_reuse");
    for (int k = 2; k < 8; k++) s(1,1,0,3'd0,0, 1,3'(k),8'((1 << k) - 1),4'(k),0,"fill_hi");
    s(1,1,1,3'd7,1, 0,3'd0,8'hFF,4'd8,0,"flush_all");
    s(1,0,1,3'd3,1, 0,3'd0,8'h00,4'd0,0,"flush_free_empty");
    s(1,0,0,3'd0,0, 0,3'd0,8'h00,4'd0,0,"no_err_after_flush");
    s(1,1,0,3'd0,0, 1,3'd0,8'h00,4'd0,0,"a0");
    s(1,1,0,3'd0,0, 1,3'd1,8'h01,4'd1,0,"a1");
    s(0,1,1,3'd0,1, 0,3'd0,8'h03,4'd2,0,"mid_reset");
    s(1,1,0,3'd0,0, 1,3'd0,8'h00,4'd0,0,"first_after_reset");
    s(1,0,0,3'd0,0, 0,3'd0,8'h01,4'd1,0,"post_reset");

    // Random traffic on the 64-slot instance; it has been held in reset until now.
    mb = '0;
    me = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      rstn6 = 1'b1;
      req6  = 1'($urandom_range(0, 1));
      fv6   = 1'($urandom_range(0, 1));
      fidx6 = 6'($urandom_range(0, 63));
      fl6   = ($urandom_range(0, 127) == 0);
      any = 1'b0;
      li  = '0;
      for (int i = 0; i < 64; i++) if (!any && !mb[i]) begin li = 6'(i); any = 1'b1; end
      eg = req6 && !fl6 && any;
      e.sel6 = 1'b1; e.gnt = eg; e.idx = eg ? li : 6'd0; e.busy = mb;
      e.cnt = 7'($countones(mb)); e.err = me; e.tag = "rand6";
      q.push_back(e);
      if (fl6) begin
        mb = '0;
        me = 1'b0;
      end else begin
        me = fv6 && !mb[fidx6];
        if (fv6 && mb[fidx6]) mb[fidx6] = 1'b0;
        if (eg) mb[li] = 1'b1;
      end
    end
    @(posedge clk); #1;
    req6 = 1'b0; fv6 = 1'b0; fl6 = 1'b0; req3 = 1'b0; fv3 = 1'b0; fl3 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("drain", "queue", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
